// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared encodings and access-error check for the data memory controller.
package data_mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2} state_e;
  function automatic logic access_err(input logic [1:0] size, input logic [31:0] addr, input int unsigned depth);
    return (32'(addr[31:2]) >= depth) || (size == 2'b11) || (size == SZ_HALF && addr[0]) ||
           (size == SZ_WORD && addr[1:0] != 2'b00);
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane enables, store replication and load extension for sub-word accesses.
module mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] ram_word_i,
  output logic [3:0]  byte_en_o,
  output logic [31:0] wdata_rep_o,
  output logic [31:0] rdata_ext_o
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = ram_word_i[{addr_lo_i, 3'b000} +: 8];
    h = addr_lo_i[1] ? ram_word_i[31:16] : ram_word_i[15:0];
    byte_en_o = size_i == SZ_BYTE ? 4'b0001 << addr_lo_i :
                size_i == SZ_HALF ? 4'b0011 << addr_lo_i :
                size_i == SZ_WORD ? 4'b1111 : 4'b0000;
    wdata_rep_o = size_i == SZ_BYTE ? {4{wdata_i[7:0]}} :
                  size_i == SZ_HALF ? {2{wdata_i[15:0]}} : wdata_i;
    rdata_ext_o = size_i == SZ_BYTE ? {{24{b[7] & ~unsigned_i}}, b} :
                  size_i == SZ_HALF ? {{16{h[15] & ~unsigned_i}}, h} : ram_word_i;
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: handshaked byte/half/word data RAM with configurable wait states.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH);
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem [DEPTH];
  logic        accept, commit, cur_we, cur_uns, cur_err;
  logic [1:0]  cur_size;
  logic [31:0] cur_addr, cur_wdata, ram_word, wdata_rep, rdata_ext;
  logic [3:0]  byte_en;
  logic [AW-1:0] idx;
  assign accept = req_valid && req_ready;
  // With zero wait states the commit edge is the accept edge, so the live inputs feed the datapath in IDLE.
  always_comb begin
    cur_we    = state_q == ST_IDLE ? req_we : we_q;
    cur_uns   = state_q == ST_IDLE ? req_unsigned : uns_q;
    cur_size  = state_q == ST_IDLE ? req_size : size_q;
    cur_addr  = state_q == ST_IDLE ? req_addr : addr_q;
    cur_wdata = state_q == ST_IDLE ? req_wdata : wdata_q;
    idx       = cur_addr[AW+1:2];
    ram_word  = mem[idx];
    cur_err   = access_err(cur_size, cur_addr, DEPTH);
    commit    = (state_q == ST_IDLE && accept && WAIT_CYCLES == 0) || (state_q == ST_WAIT && cnt_q == 4'd0);
  end
  mem_lane_align u_align (
    .size_i      (cur_size),
    .addr_lo_i   (cur_addr[1:0]),
    .unsigned_i  (cur_uns),
    .wdata_i     (cur_wdata),
    .ram_word_i  (ram_word),
    .byte_en_o   (byte_en),
    .wdata_rep_o (wdata_rep),
    .rdata_ext_o (rdata_ext)
  );
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == ST_IDLE ? (accept ? (WAIT_CYCLES == 0 ? ST_RESP : ST_WAIT) : ST_IDLE) :
              state_q == ST_WAIT ? (cnt_q == 4'd0 ? ST_RESP : ST_WAIT) :
              (rsp_ready ? ST_IDLE : ST_RESP);
  end
  always_comb begin
    req_ready = state_q == ST_IDLE;
    rsp_valid = state_q == ST_RESP;
  end
  always_comb begin
    cnt_d   = (accept && WAIT_CYCLES != 0) ? 4'(WAIT_CYCLES - 1) :
              (state_q == ST_WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    rdata_d = commit ? ((cur_err || cur_we) ? 32'd0 : rdata_ext) : rdata_q;
    err_d   = commit ? cur_err : err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end
  // RAM is not reset; reset still blocks a write that lands on the commit edge.
  always_ff @(posedge clk) begin
    if (!rst && commit && cur_we && !cur_err)
      for (int i = 0; i < 4; i++)
        if (byte_en[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
  end
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed checks of a zero-wait and a three-wait instance of data_mem_ctrl.
module tb_data_mem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic va, vb, we, uns, rsp_ready;
  logic [1:0] size;
  logic [31:0] addr, wdata;
  logic ra, rb, sva, svb, ea, eb;
  logic [31:0] da, db;
  int total = 0, bad = 0;
  data_mem_ctrl #(.DEPTH(256), .WAIT_CYCLES(0)) u_a (
    .clk(clk), .rst(rst), .req_valid(va), .req_ready(ra), .req_we(we), .req_size(size),
    .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata), .rsp_valid(sva),
    .rsp_ready(rsp_ready), .rsp_rdata(da), .rsp_err(ea)
  );
  data_mem_ctrl #(.DEPTH(256), .WAIT_CYCLES(3)) u_b (
    .clk(clk), .rst(rst), .req_valid(vb), .req_ready(rb), .req_we(we), .req_size(size),
    .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata), .rsp_valid(svb),
    .rsp_ready(rsp_ready), .rsp_rdata(db), .rsp_err(eb)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic acc(input bit s, input bit w, input logic [1:0] sz, input bit u, input logic [31:0] a,
                     input logic [31:0] d, input int hold, output logic [31:0] rd, output logic e, output int lat);
    bit busy_rdy;
    busy_rdy = 1'b0;
    @(negedge clk);
    we = w; size = sz; uns = u; addr = a; wdata = d; rsp_ready = (hold == 0);
    if (s) vb = 1'b1; else va = 1'b1;
    lat = 0;
    while (!(s ? rb : ra) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    @(negedge clk);
    va = 1'b0; vb = 1'b0; we = ~w; size = ~sz; uns = ~u; addr = ~a; wdata = ~d;
    lat = 1;
    while (!(s ? svb : sva) && lat < 40) begin
      busy_rdy |= (s ? rb : ra);
      @(negedge clk);
      lat++;
    end
    busy_rdy |= (s ? rb : ra);
    rd = s ? db : da;
    e  = s ? eb : ea;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_v", s ? svb : sva, 1);
      chk("hold_d", s ? db : da, rd);
      chk("hold_e", s ? eb : ea, e);
      busy_rdy |= (s ? rb : ra);
    end
    chk("busy_rdy", busy_rdy, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("idle_rdy", s ? rb : ra, 1);
    chk("idle_v", s ? svb : sva, 0);
  endtask
  task automatic t(input string tag, input bit s, input bit w, input logic [1:0] sz, input bit u,
                   input logic [31:0] a, input logic [31:0] d, input int hold,
                   input logic [31:0] exp_rd, input logic exp_e, input int exp_lat);
    logic [31:0] rd;
    logic e;
    int lat;
    acc(s, w, sz, u, a, d, hold, rd, e, lat);
    chk({tag, "_rd"}, rd, exp_rd);
    chk({tag, "_err"}, e, exp_e);
    chk({tag, "_lat"}, lat, exp_lat);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    va = 0; vb = 0; we = 0; size = 0; uns = 0; addr = 0; wdata = 0; rsp_ready = 1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_rdy_a", ra, 1);
    chk("rst_v_a", sva, 0);
    chk("rst_d_a", da, 0);
    chk("rst_e_a", ea, 0);
    chk("rst_rdy_b", rb, 1);
    chk("rst_v_b", svb, 0);
    t("st_w",     0, 1, 2'b10, 0, 32'h10,  32'hDEADBEEF, 0, 32'h0,        0, 1);
    t("ld_b_s",   0, 0, 2'b00, 0, 32'h13,  32'h0,        0, 32'hFFFFFFDE, 0, 1);
    t("ld_h_u",   0, 0, 2'b01, 1, 32'h10,  32'h0,        0, 32'h0000BEEF, 0, 1);
    t("st_b",     0, 1, 2'b00, 0, 32'h11,  32'hAAAAAA55, 0, 32'h0,        0, 1);
    t("ld_w",     0, 0, 2'b10, 0, 32'h10,  32'h0,        0, 32'hDEAD55EF, 0, 1);
    t("ld_h_s",   0, 0, 2'b01, 0, 32'h12,  32'h0,        0, 32'hFFFFDEAD, 0, 1);
    t("ld_b_u",   0, 0, 2'b00, 1, 32'h13,  32'h0,        0, 32'h000000DE, 0, 1);
    t("ld_w_mis", 0, 0, 2'b10, 0, 32'h12,  32'h0,        0, 32'h0,        1, 1);
    t("st_w0",    0, 1, 2'b10, 0, 32'h0,   32'h12345678, 0, 32'h0,        0, 1);
    t("st_oor",   0, 1, 2'b10, 0, 32'h400, 32'hFFFFFFFF, 0, 32'h0,        1, 1);
    t("ld_w0",    0, 0, 2'b10, 0, 32'h0,   32'h0,        0, 32'h12345678, 0, 1);
    t("st_h_mis", 0, 1, 2'b01, 0, 32'h3,   32'hFFFFFFFF, 0, 32'h0,        1, 1);
    t("ld_ill",   0, 0, 2'b11, 0, 32'h0,   32'h0,        0, 32'h0,        1, 1);
    t("ld_w0b",   0, 0, 2'b10, 0, 32'h0,   32'h0,        0, 32'h12345678, 0, 1);
    t("st_w14",   0, 1, 2'b10, 0, 32'h14,  32'h0,        0, 32'h0,        0, 1);
    t("st_h16",   0, 1, 2'b01, 0, 32'h16,  32'h1234A5C3, 0, 32'h0,        0, 1);
    t("ld_w14",   0, 0, 2'b10, 0, 32'h14,  32'h0,        0, 32'hA5C30000, 0, 1);
    t("ld_h16_s", 0, 0, 2'b01, 0, 32'h16,  32'h0,        0, 32'hFFFFA5C3, 0, 1);
    t("b_st",     1, 1, 2'b10, 0, 32'h20,  32'h11111111, 0, 32'h0,        0, 4);
    t("b_hold",   1, 0, 2'b10, 0, 32'h20,  32'h0,        2, 32'h11111111, 0, 4);
    // Reset lands on the commit edge of a wait-state store.
    @(negedge clk);
    we = 1; size = 2'b10; uns = 0; addr = 32'h20; wdata = 32'h22222222; vb = 1;
    @(negedge clk);
    vb = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rc_rdy", rb, 1);
    chk("rc_v", svb, 0);
    chk("rc_d", db, 0);
    t("b_ld_rst", 1, 0, 2'b10, 0, 32'h20, 32'h0, 0, 32'h11111111, 0, 4);
    t("ld_w0_rst", 0, 0, 2'b10, 0, 32'h0, 32'h0, 0, 32'h12345678, 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised successor to the single-cycle word-only data RAM. It serves the load/store stage through a valid/ready request and response handshake. It supports byte, halfword and word accesses, with byte-lane write enables and sign or zero extension on loads. Depth and wait-state count are configurable, so the same block can model both fast and slow memory. Misaligned and out-of-range accesses are flagged and have no side effect.

## Interface
- `DEPTH`, default 256: number of 32-bit words; power of two, at least 4.
- `WAIT_CYCLES`, default 0: extra cycles between accept and response; range 0..15.
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned` in 1: on loads, 1 = zero-extend, 0 = sign-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_rdata` out 32: load result, extended; 0 for stores and errors.
- `rsp_err` out 1: access was misaligned, illegal-size or out of range.

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
- `req_ready` = 1 only in IDLE. A request is accepted when `req_valid` && `req_ready`, and its fields are latched into request registers.
- Transitions:
  - IDLE -> WAIT on accept when `WAIT_CYCLES` > 0.
  - IDLE -> RESP on accept when `WAIT_CYCLES` = 0.
  - WAIT counts down from `WAIT_CYCLES`-1; at 0 it goes to RESP.
  - RESP -> IDLE when `rsp_ready` = 1.
- Commit edge is the edge entering RESP. At that edge:
  - a store writes the enabled byte lanes;
  - a load captures the extended word into `rsp_rdata`.
- Word index = `addr[log2(DEPTH)+1:2]`.
- Out-of-range when `addr[31:2]` >= `DEPTH`.
- Store byte enables:
  - byte: 4'b0001 << `addr[1:0]`;
  - half: 4'b0011 << `addr[1:0]`;
  - word: 4'b1111.
  - Write data is replicated across the lanes.
- Load extraction:
  - byte lane = `addr[1:0]`;
  - half lane = `addr[1]`;
  - bit 7 or bit 15 supplies the sign unless `req_unsigned` is set.
- Error conditions:
  - size 11;
  - half with `addr[0]` = 1;
  - word with `addr[1:0]` != 0;
  - out of range.
- On error: no write, `rsp_rdata` = 0, `rsp_err` = 1.
- RAM contents are not reset and are undefined until written.

## Timing
- Reset values: state IDLE, `req_ready` = 1 in the cycle after reset, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0, wait counter 0.
- Latency: `rsp_valid` rises `WAIT_CYCLES`+1 cycles after the accept edge.
- Throughput is one access per `WAIT_CYCLES`+2 cycles when `rsp_ready` is held at 1.
- `rsp_valid`, `rsp_rdata` and `rsp_err` are registered and held stable while `rsp_ready` = 0.
- No request is accepted while a response is pending; `req_ready` returns to 1 in the cycle after the RESP handshake.
- Reset has priority over everything, including the commit edge. If reset is asserted mid-request, the pending access is dropped and no write occurs when reset coincides with the commit edge.
- Request inputs are ignored after accept; changing them in WAIT has no effect.
- A load of an address stored earlier returns the new data. There is no same-cycle hazard, because requests are serialised.

## Structure
- Package `data_mem_pkg` holds:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - FSM state encodings `ST_IDLE`, `ST_WAIT`, `ST_RESP`;
  - the function computing the error flag.
- Sub-module `mem_lane_align` is purely combinational. It maps (size, `addr[1:0]`, unsigned, `wdata`, `ram_word`) to (`byte_en`, `wdata_rep`, `rdata_ext`). It is reusable by the future cache.
- The top module holds the FSM, wait counter, request registers and RAM array.

## Test plan
- Reset with `WAIT_CYCLES` = 0 -> `req_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0.
- Store word 0xDEADBEEF @0x10, then load byte signed @0x13 -> `rsp_rdata` 0xFFFFFFDE. Load half unsigned @0x10 -> 0x0000BEEF.
- Store byte 0x55 @0x11 over 0xDEADBEEF, then load word @0x10 -> 0xDEAD55EF.
- Load word @0x12 -> `rsp_err` = 1, `rdata` = 0. Store word @(4·`DEPTH`) -> `rsp_err` = 1, and a later read of word 0 is unchanged.
- `WAIT_CYCLES` = 3, `rsp_ready` low for 2 cycles -> `rsp_valid` rises 4 cycles after accept, holds its data, and `req_ready` = 0 throughout.
- Assert `rst` on the commit edge of a store to @0x20 -> after reset, a load @0x20 returns the prior value and the FSM is in IDLE.
